// File: rtl/max_unpool.sv
// max_unpool: scatters each pooled-layer error back into its STRIDE x STRIDE
// pre-pool window. The error goes to the stored argmax position, and zero goes
// to every other position.
// Optional build macro: MAX_UNPOOL_SKIP_ZERO_EN. When it is defined, only the
// argmax write is issued for each window (the destination memory is assumed to
// be pre-cleared), and an out-of-range argmax issues no write at all.
module max_unpool #(
  parameter int  INPUT_WIDTH    = 64,
  parameter int  INPUT_HEIGHT   = 64,
  parameter int  INPUT_CHANNELS = 30,
  parameter int  STRIDE         = 2,
  localparam int PW    = INPUT_WIDTH / STRIDE,
  localparam int PH    = INPUT_HEIGHT / STRIDE,
  localparam int WIN   = STRIDE * STRIDE,
  localparam int OA_W  = (PW * PH * INPUT_CHANNELS > 1) ? $clog2(PW * PH * INPUT_CHANNELS) : 1,
  localparam int IA_W  = (INPUT_WIDTH * INPUT_HEIGHT * INPUT_CHANNELS > 1) ?
                         $clog2(INPUT_WIDTH * INPUT_HEIGHT * INPUT_CHANNELS) : 1,
  localparam int IDX_W = (WIN > 1) ? $clog2(WIN) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [OA_W-1:0]  out_err_addr,
  input  logic             out_err_valid,
  input  logic [15:0]      out_err_data,
  input  logic [IDX_W-1:0] max_idx,
  output logic [IA_W-1:0]  in_err_addr,
  output logic [15:0]      in_err_data,
  output logic             in_err_valid,
  input  logic             in_err_ready,
  output logic             busy,
  output logic             done
);

  localparam int OX_W = (PW > 1) ? $clog2(PW) : 1;
  localparam int OY_W = (PH > 1) ? $clog2(PH) : 1;
  localparam int CH_W = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    SCATTER = 3'd2,
    NEXT    = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [OX_W-1:0]  ox_q;
  logic [OY_W-1:0]  oy_q;
  logic [CH_W-1:0]  ch_q;
  logic [15:0]      err_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] k_sel;
  logic             last_ox, last_oy, last_ch, last_win;
  logic             wr_fire;
  logic             scatter_end;

`ifndef MAX_UNPOOL_SKIP_ZERO_EN
  logic [IDX_W-1:0] k_q;
`else
  logic             idx_ok;
`endif

  assign last_ox  = (ox_q == OX_W'(PW - 1));
  assign last_oy  = (oy_q == OY_W'(PH - 1));
  assign last_ch  = (ch_q == CH_W'(INPUT_CHANNELS - 1));
  assign last_win = last_ox && last_oy && last_ch;
  assign wr_fire  = in_err_valid && in_err_ready;

`ifdef MAX_UNPOOL_SKIP_ZERO_EN
  // Only the argmax slot is written, so the window offset is the argmax itself.
  assign idx_ok      = (32'(idx_q) < 32'(WIN));
  assign k_sel       = idx_q;
  assign scatter_end = !idx_ok || wr_fire;
  assign in_err_data = in_err_valid ? err_q : 16'h0000;
`else
  // Every slot is visited in order; only the argmax slot carries the error.
  assign k_sel       = k_q;
  assign scatter_end = wr_fire && (k_q == IDX_W'(WIN - 1));
  assign in_err_data = (in_err_valid && (k_q == idx_q)) ? err_q : 16'h0000;
`endif

  // Linear pooled index of the current window: channel-major, then row, then column.
  assign out_err_addr = OA_W'(ch_q) * OA_W'(PW * PH)
                      + OA_W'(oy_q) * OA_W'(PW)
                      + OA_W'(ox_q);

  // Pre-pool address: window origin plus the row/column offset of slot k.
  assign in_err_addr = IA_W'(ch_q) * IA_W'(INPUT_WIDTH * INPUT_HEIGHT)
                     + IA_W'(oy_q) * IA_W'(STRIDE * INPUT_WIDTH)
                     + IA_W'(ox_q) * IA_W'(STRIDE)
                     + IA_W'(k_sel / IDX_W'(STRIDE)) * IA_W'(INPUT_WIDTH)
                     + IA_W'(k_sel % IDX_W'(STRIDE));

  // State register; reset drops straight back to IDLE even mid-window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = FETCH;
      FETCH:   if (out_err_valid) state_d = SCATTER;
      SCATTER: if (scatter_end) state_d = NEXT;
      NEXT:    state_d = last_win ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
`ifdef MAX_UNPOOL_SKIP_ZERO_EN
    in_err_valid = (state_q == SCATTER) && idx_ok;
`else
    in_err_valid = (state_q == SCATTER);
`endif
  end

  // Window counters and the captured error/argmax for the current window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ox_q  <= '0;
      oy_q  <= '0;
      ch_q  <= '0;
      err_q <= '0;
      idx_q <= '0;
`ifndef MAX_UNPOOL_SKIP_ZERO_EN
      k_q   <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            ox_q <= '0;
            oy_q <= '0;
            ch_q <= '0;
          end
        end
        FETCH: begin
          if (out_err_valid) begin
            err_q <= out_err_data;
            idx_q <= max_idx;
`ifndef MAX_UNPOOL_SKIP_ZERO_EN
            k_q   <= '0;
`endif
          end
        end
        SCATTER: begin
`ifndef MAX_UNPOOL_SKIP_ZERO_EN
          if (wr_fire && !scatter_end) k_q <= k_q + IDX_W'(1);
`endif
        end
        NEXT: begin
          if (!last_ox) begin
            ox_q <= ox_q + OX_W'(1);
          end else begin
            ox_q <= '0;
            if (!last_oy) begin
              oy_q <= oy_q + OY_W'(1);
            end else begin
              oy_q <= '0;
              ch_q <= last_ch ? '0 : ch_q + CH_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_max_unpool.sv
// Bench for max_unpool: a 4x4x1 instance and a 4x4x2 instance, each fed by a
// small pooled-error memory model. Expected writes come from a reference
// scatter model and are queued when a pass starts.
module tb_max_unpool;

`ifdef MAX_UNPOOL_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  localparam int NWR1 = SKIP ? 4 : 16;
  localparam int NWR2 = SKIP ? 8 : 32;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 1: W=H=4, C=1, S=2
  logic        enable;
  logic [1:0]  oaddr;
  logic        ovalid;
  logic [15:0] odata;
  logic [1:0]  midx;
  logic [3:0]  iaddr;
  logic [15:0] idata;
  logic        ivalid;
  logic        iready;
  logic        busy, done;

  // Instance 2: W=H=4, C=2, S=2
  logic        enable2;
  logic [2:0]  b_oaddr;
  logic        b_ovalid;
  logic [15:0] b_odata;
  logic [1:0]  b_midx;
  logic [4:0]  b_iaddr;
  logic [15:0] b_idata;
  logic        b_ivalid;
  logic        b_iready;
  logic        b_busy, b_done;

  max_unpool #(.INPUT_WIDTH(4), .INPUT_HEIGHT(4), .INPUT_CHANNELS(1), .STRIDE(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .out_err_addr(oaddr), .out_err_valid(ovalid), .out_err_data(odata), .max_idx(midx),
    .in_err_addr(iaddr), .in_err_data(idata), .in_err_valid(ivalid), .in_err_ready(iready),
    .busy(busy), .done(done)
  );

  max_unpool #(.INPUT_WIDTH(4), .INPUT_HEIGHT(4), .INPUT_CHANNELS(2), .STRIDE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .enable(enable2),
    .out_err_addr(b_oaddr), .out_err_valid(b_ovalid), .out_err_data(b_odata), .max_idx(b_midx),
    .in_err_addr(b_iaddr), .in_err_data(b_idata), .in_err_valid(b_ivalid), .in_err_ready(b_iready),
    .busy(b_busy), .done(b_done)
  );

  // Pooled-error memories.
  logic [15:0] err_mem1 [4];
  logic [1:0]  idx_mem1 [4];
  logic [15:0] err_mem2 [8];
  logic [1:0]  idx_mem2 [8];

  // Read model for instance 1: data valid lat1 cycles after the address settles.
  int         lat1 = 1;
  logic [1:0] raddr1 = 2'd0;
  int         rcnt1 = 0;
  always @(posedge clk) begin
    rcnt1  <= (oaddr == raddr1) ? rcnt1 + 1 : 0;
    raddr1 <= oaddr;
  end
  assign ovalid = (lat1 == 0) || ((oaddr == raddr1) && (rcnt1 >= lat1 - 1));
  assign odata  = err_mem1[oaddr];
  assign midx   = idx_mem1[oaddr];

  // Instance 2 sees zero-latency reads and a permanently asserted valid.
  assign b_ovalid = 1'b1;
  assign b_odata  = err_mem2[b_oaddr];
  assign b_midx   = idx_mem2[b_oaddr];
  assign b_iready = 1'b1;

  wr_t exp1[$];
  wr_t exp2[$];
  int  wcyc1[$];
  int  wcyc2[$];
  int  waddr2[$];
  int  hit[16];
  int  wr1 = 0, done1 = 0, wr2 = 0;
  int  rmode = 0;

  // Monitor 1: drives ready, samples the handshake away from the edge, and
  // commits it at the edge if reset is still released.
  initial begin
    wr_t s;
    wr_t pv;
    bit  s_v, s_done, pv_stall, pv_done;
    pv_stall = 1'b0;
    pv_done  = 1'b0;
    iready   = 1'b1;
    forever begin
      @(negedge clk);
      case (rmode)
        0:       iready = 1'b1;
        1:       iready = ~iready;
        default: iready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (reset_n === 1'b1) begin
        if (pv_stall) begin
          tests_run++;
          if (ivalid !== 1'b1 || int'(iaddr) !== pv.addr || int'(idata) !== pv.data) begin
            tests_failed++;
            $display("FAIL stall_hold: valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                     ivalid, iaddr, idata, pv.addr, pv.data);
          end
        end
        if (pv_done) begin
          tests_run++;
          if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_after_done: busy=%b, required 0", busy);
          end
        end
      end
      s_v      = (ivalid === 1'b1) && (iready === 1'b1);
      s.addr   = int'(iaddr);
      s.data   = int'(idata);
      pv       = s;
      pv_stall = (ivalid === 1'b1) && (iready === 1'b0);
      s_done   = (done === 1'b1);
      pv_done  = s_done;
      @(posedge clk);
      if (reset_n !== 1'b1) begin
        pv_stall = 1'b0;
        pv_done  = 1'b0;
      end else begin
        if (s_done) done1++;
        if (s_v) begin
          tests_run++;
          if (exp1.size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_write: addr=%0d data=%h, required no write", s.addr, s.data);
          end else begin
            wr_t e;
            e = exp1.pop_front();
            if (s.addr !== e.addr || s.data !== e.data) begin
              tests_failed++;
              $display("FAIL write_seq: addr=%0d data=%h, required addr=%0d data=%h",
                       s.addr, s.data, e.addr, e.data);
            end
          end
          wr1++;
          if (s.addr >= 0 && s.addr < 16) hit[s.addr]++;
          wcyc1.push_back(cyc);
        end
      end
    end
  end

  // Monitor 2: ready is always high; check each write against the scoreboard.
  initial begin
    wr_t s;
    bit  s_v;
    forever begin
      @(negedge clk);
      #1;
      s_v    = (b_ivalid === 1'b1);
      s.addr = int'(b_iaddr);
      s.data = int'(b_idata);
      @(posedge clk);
      if (reset_n === 1'b1 && s_v) begin
        tests_run++;
        if (exp2.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_write2: addr=%0d data=%h, required no write", s.addr, s.data);
        end else begin
          wr_t e;
          e = exp2.pop_front();
          if (s.addr !== e.addr || s.data !== e.data) begin
            tests_failed++;
            $display("FAIL write_seq2: addr=%0d data=%h, required addr=%0d data=%h",
                     s.addr, s.data, e.addr, e.data);
          end
        end
        wr2++;
        waddr2.push_back(s.addr);
        wcyc2.push_back(cyc);
      end
    end
  end

  // Reference scatter model for one pass over nch channels.
  task automatic push_exp(input int which, input int nch);
    wr_t w;
    int  p, ix, e;
    for (int ch = 0; ch < nch; ch++)
      for (int oy = 0; oy < 2; oy++)
        for (int ox = 0; ox < 2; ox++) begin
          p  = ch * 4 + oy * 2 + ox;
          e  = (which == 0) ? int'(err_mem1[p]) : int'(err_mem2[p]);
          ix = (which == 0) ? int'(idx_mem1[p]) : int'(idx_mem2[p]);
          for (int k = 0; k < 4; k++) begin
            if (SKIP && k != ix) continue;
            w.addr = ch * 16 + oy * 8 + ox * 2 + (k / 2) * 4 + (k % 2);
            w.data = (k == ix) ? e : 0;
            if (which == 0) exp1.push_back(w);
            else            exp2.push_back(w);
          end
        end
  endtask

  task automatic fill_mem1();
    for (int i = 0; i < 4; i++) begin
      err_mem1[i] = 16'($urandom_range(1, 16'hFFFF));
      idx_mem1[i] = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic run_pass1(input string name);
    int d0, w0, t;
    d0 = done1;
    w0 = wr1;
    for (int i = 0; i < 16; i++) hit[i] = 0;
    push_exp(0, 1);
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    t = 0;
    while (done1 == d0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (done1 != d0 + 1) begin
      tests_failed++;
      $display("FAIL %s_done_count: %0d done pulses, required 1", name, done1 - d0);
    end
    tests_run++;
    if (wr1 - w0 != NWR1) begin
      tests_failed++;
      $display("FAIL %s_write_count: %0d writes, required %0d", name, wr1 - w0, NWR1);
    end
    tests_run++;
    if (exp1.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_missing_writes: %0d left, required 0", name, exp1.size());
    end
    exp1.delete();
  endtask

  task automatic check_hits(input string name);
    int exph[16];
    int bad, ix, a;
    bad = -1;
    for (int i = 0; i < 16; i++) exph[i] = 0;
    for (int p = 0; p < 4; p++) begin
      ix = int'(idx_mem1[p]);
      for (int k = 0; k < 4; k++) begin
        a = (p / 2) * 8 + (p % 2) * 2 + (k / 2) * 4 + (k % 2);
        if (!SKIP || k == ix) exph[a]++;
      end
    end
    for (int i = 0; i < 16; i++) if (hit[i] != exph[i] && bad < 0) bad = i;
    tests_run++;
    if (bad >= 0) begin
      tests_failed++;
      $display("FAIL %s_coverage: addr %0d written %0d times, required %0d",
               name, bad, hit[bad], exph[bad]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); #3 reset_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || ivalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b done=%b valid=%b, required 0 0 0", busy, done, ivalid);
    end
    tests_run++;
    if (iaddr !== 4'd0 || idata !== 16'h0 || oaddr !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_data: iaddr=%0d idata=%h oaddr=%0d, required 0 0 0", iaddr, idata, oaddr);
    end
    tests_run++;
    if (b_busy !== 1'b0 || b_ivalid !== 1'b0 || b_oaddr !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_dut2: busy=%b valid=%b oaddr=%0d, required 0 0 0", b_busy, b_ivalid, b_oaddr);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    tests_run++;
    if (wr1 != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: writes=%0d busy=%b, required 0 0", wr1, busy);
    end
  endtask

  task automatic test_window0();
    fill_mem1();
    err_mem1[0] = 16'h0123;
    idx_mem1[0] = 2'd3;
    lat1 = 1;
    rmode = 0;
    wcyc1.delete();
    run_pass1("window0");
`ifndef MAX_UNPOOL_SKIP_ZERO_EN
    tests_run++;
    if (wcyc1.size() < 4 || wcyc1[3] - wcyc1[0] != 3) begin
      tests_failed++;
      $display("FAIL window0_consecutive: span=%0d cycles, required 3",
               (wcyc1.size() < 4) ? -1 : wcyc1[3] - wcyc1[0]);
    end
`endif
  endtask

  task automatic test_full_pass();
    fill_mem1();
    lat1 = 1;
    rmode = 0;
    run_pass1("full_pass");
    check_hits("full_pass");
  endtask

  task automatic test_ready_toggle();
    fill_mem1();
    lat1 = 2;
    rmode = 1;
    run_pass1("ready_toggle");
    check_hits("ready_toggle");
  endtask

  task automatic test_ready_random();
    fill_mem1();
    lat1 = 3;
    rmode = 2;
    run_pass1("ready_random");
    check_hits("ready_random");
    rmode = 0;
  endtask

  task automatic test_argmax_one();
    fill_mem1();
    for (int i = 0; i < 4; i++) idx_mem1[i] = 2'd1;
    lat1 = 1;
    rmode = 0;
    run_pass1("argmax_one");
    check_hits("argmax_one");
  endtask

  task automatic test_reset_mid();
    int w0, t, target, nbefore;
    fill_mem1();
    lat1 = 1;
    rmode = 0;
    target  = SKIP ? 8 + (int'(idx_mem1[2]) / 2) * 4 + (int'(idx_mem1[2]) % 2) : 9;
    nbefore = SKIP ? 2 : 9;
    push_exp(0, 1);
    w0 = wr1;
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    t = 0;
    do begin
      @(posedge clk); #2;
      t++;
    end while (!(ivalid === 1'b1 && int'(iaddr) == target) && t < 500);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (ivalid !== 1'b0 || busy !== 1'b0 || iaddr !== 4'd0 || oaddr !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_clear: valid=%b busy=%b iaddr=%0d oaddr=%0d, required 0 0 0 0",
               ivalid, busy, iaddr, oaddr);
    end
    tests_run++;
    if (wr1 - w0 != nbefore) begin
      tests_failed++;
      $display("FAIL mid_reset_writes: %0d writes before reset, required %0d", wr1 - w0, nbefore);
    end
    exp1.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    w0 = wr1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (wr1 != w0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL no_write_after_reset: writes=%0d busy=%b, required 0 0", wr1 - w0, busy);
    end
    run_pass1("restart");
    check_hits("restart");
  endtask

  task automatic test_back_to_back();
    int n, t, dcyc, ix, base_exp, gap;
    for (int i = 0; i < 8; i++) begin
      err_mem2[i] = 16'($urandom_range(1, 16'hFFFF));
      idx_mem2[i] = 2'($urandom_range(0, 3));
    end
    push_exp(1, 2);
    push_exp(1, 2);
    wcyc2.delete();
    waddr2.delete();
    wr2 = 0;
    n = 0;
    t = 0;
    dcyc = 0;
    @(negedge clk); enable2 = 1'b1;
    while (n < 2 && t < 3000) begin
      @(negedge clk); #2;
      t++;
      if (b_done === 1'b1) begin
        n++;
        if (n == 1) dcyc = cyc;
        if (n == 2) enable2 = 1'b0;
      end
    end
    enable2 = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++;
    if (n != 2) begin
      tests_failed++;
      $display("FAIL b2b_done_count: %0d done pulses, required 2", n);
    end
    tests_run++;
    if (wr2 != 2 * NWR2 || exp2.size() != 0) begin
      tests_failed++;
      $display("FAIL b2b_write_count: %0d writes, %0d missing, required %0d and 0",
               wr2, exp2.size(), 2 * NWR2);
    end
    ix = int'(idx_mem2[4]);
    base_exp = SKIP ? 16 + (ix / 2) * 4 + (ix % 2) : 16;
    tests_run++;
    if (waddr2.size() <= NWR2 / 2 || waddr2[NWR2 / 2] != base_exp) begin
      tests_failed++;
      $display("FAIL ch1_base_addr: addr=%0d, required %0d",
               (waddr2.size() <= NWR2 / 2) ? -1 : waddr2[NWR2 / 2], base_exp);
    end
    gap = (wcyc2.size() > NWR2) ? wcyc2[NWR2] - dcyc : -1;
    tests_run++;
    if (gap < 1 || gap > 4) begin
      tests_failed++;
      $display("FAIL b2b_restart_gap: %0d cycles from done to next write, required 1..4", gap);
    end
    exp2.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    enable2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      err_mem1[i] = 16'h0;
      idx_mem1[i] = 2'd0;
    end
    for (int i = 0; i < 8; i++) begin
      err_mem2[i] = 16'h0;
      idx_mem2[i] = 2'd0;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    test_reset();
    test_window0();
    test_full_pass();
    test_ready_toggle();
    test_ready_random();
    test_argmax_one();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/max_unpool.md
MAX_UNPOOL -- requirements
Module: max_unpool

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 64, pre-pool feature-map width.
REQ-002 SHALL have parameter INPUT_HEIGHT, default 64, pre-pool feature-map height.
REQ-003 SHALL have parameter INPUT_CHANNELS, default 30, channel count.
REQ-004 SHALL have parameter STRIDE, default 2, square window side and step.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, 1, start request, sampled in IDLE only.
REQ-008 SHALL have port out_err_addr, output, clog2((W/S)*(H/S)*C), pooled-error read address.
REQ-009 SHALL have port out_err_valid, input, 1, read data valid.
REQ-010 SHALL have port out_err_data, input, 16, pooled-layer error.
REQ-011 SHALL have port max_idx, input, clog2(S*S), stored argmax of the window at out_err_addr, valid with out_err_valid.
REQ-012 SHALL have port in_err_addr, output, clog2(W*H*C), pre-pool error write address.
REQ-013 SHALL have port in_err_data, output, 16, pre-pool error write data.
REQ-014 SHALL have port in_err_valid, output, 1, write request.
REQ-015 SHALL have port in_err_ready, input, 1, write accept.
REQ-016 SHALL have ports busy and done, outputs, 1 each: active-run flag and one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, FETCH, SCATTER, NEXT, DONE; IDLE->FETCH on enable=1.
REQ-018 FETCH SHALL drive out_err_addr = linear pooled index; capture out_err_data and max_idx on the first cycle out_err_valid=1, then go to SCATTER; read latency unbounded.
REQ-019 SCATTER SHALL issue S*S writes, k=0..S*S-1, in_err_addr = ch*W*H + oy*S*W + ox*S + (k/S)*W + (k%S).
REQ-020 in_err_data SHALL equal captured error when k==max_idx, else 16'h0000; max_idx >= S*S yields all-zero window.
REQ-021 A write SHALL complete only on in_err_valid & in_err_ready; address/data held stable while ready=0; with ready held high, one write per cycle.
REQ-022 NEXT SHALL advance ox fastest, then oy, then ch; after the last window (W/S-1, H/S-1, C-1) go to DONE, else FETCH.
REQ-023 DONE SHALL pulse done for exactly one cycle and return to IDLE; busy=1 in every state except IDLE.
REQ-024 enable asserted while busy SHALL be ignored; enable held high in IDLE after DONE SHALL start a new pass.
REQ-025 Out_err_valid outside FETCH SHALL be ignored.

Reset
REQ-026 reset_n=0 SHALL immediately force IDLE and clear busy, done, in_err_valid, in_err_addr, in_err_data, out_err_addr, and all counters to 0, including mid-SCATTER.
REQ-027 After reset_n release, no write SHALL be issued until a new enable.

Configuration
REQ-028 Macro MAX_UNPOOL_SKIP_ZERO_EN SHALL, when defined, issue only the single argmax write per window (destination pre-cleared by system); out-of-range max_idx then issues no write.
REQ-029 Without MAX_UNPOOL_SKIP_ZERO_EN, SHALL issue all S*S writes per window per REQ-019/020.

Verification (W=H=4, C=1, S=2 unless noted)
REQ-030 Error 16'h0123, max_idx=3 at window 0, ready=1 -> writes addr0=0, addr1=0, addr4=0, addr5=16'h0123 on four consecutive cycles.
REQ-031 Full pass, ready=1, read latency 1 -> 16 writes, every input address 0..15 written once, done pulses once, busy falls the cycle after.
REQ-032 ready toggled 0/1 every cycle -> write sequence identical to REQ-031, no address skipped or duplicated.
REQ-033 reset_n low during 2nd write of window 2 -> in_err_valid=0 same cycle, IDLE; subsequent enable restarts at window 0.
REQ-034 MAX_UNPOOL_SKIP_ZERO_EN defined, max_idx=1 all windows -> exactly 4 writes at addresses 1, 3, 9, 11.
REQ-035 C=2, enable held high through run -> second pass starts immediately after done; ch=1 window 0 writes base address 16.
